// File: rtl/interp_pkg.sv
// interp_pkg: widths and types shared by the interpolator and the moving-average filter.
package interp_pkg;
    localparam int DATA_W    = 32;
    localparam int LOG2_TAPS = 3;
    localparam int CNT_W     = 9;
    localparam int TAPS      = 1 << LOG2_TAPS;
    localparam int ACC_W     = DATA_W + LOG2_TAPS;
    localparam logic [LOG2_TAPS:0] FILL_MAX = (LOG2_TAPS + 1)'(TAPS);
    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [ACC_W-1:0]  acc_t;
endpackage

// File: rtl/ma_filter_if.sv
// ma_filter_if: sample stream into the filter and the filtered stream plus status out.
interface ma_filter_if;
    import interp_pkg::*;
    sample_t          din;
    logic             din_valid;
    sample_t          x_filt;
    logic             x_filt_valid;
    logic             primed;
    logic [CNT_W-1:0] cnt;
    modport master (output din, din_valid, input x_filt, x_filt_valid, primed, cnt);
    modport slave  (input din, din_valid, output x_filt, x_filt_valid, primed, cnt);
endinterface

// File: rtl/ma_delay_line.sv
// ma_delay_line: circular TAPS-word buffer; the word at wp is the oldest and is read before overwrite.
module ma_delay_line
    import interp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [LOG2_TAPS-1:0] wp,
    input  sample_t              din,
    output sample_t              oldest
);
    sample_t mem [TAPS];
    assign oldest = mem[wp];
    always_ff @(posedge clk)
        if (rst)
            for (int i = 0; i < TAPS; i++) mem[i] <= '0;
        else if (we)
            mem[wp] <= din;
endmodule

// File: rtl/ma_filter.sv
// ma_filter: TAPS-tap boxcar average using a running sum and a circular delay line.
module ma_filter
    import interp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ma_filter_if.slave bus
);
    acc_t                 acc;
    logic [LOG2_TAPS-1:0] wp;
    logic [LOG2_TAPS:0]   fill, fill_nxt;
    logic                 v1;
    sample_t              oldest;
    ma_delay_line u_line (
        .clk    (clk),
        .rst    (rst),
        .we     (bus.din_valid),
        .wp     (wp),
        .din    (bus.din),
        .oldest (oldest)
    );
    // primed is taken from the next fill value so it rises with the TAPS-th sample
    always_comb fill_nxt = (bus.din_valid && fill != FILL_MAX) ? fill + 1'b1 : fill;
    always_ff @(posedge clk) begin
        if (rst) begin
            acc              <= '0;
            wp               <= '0;
            fill             <= '0;
            v1               <= 1'b0;
            bus.x_filt       <= '0;
            bus.x_filt_valid <= 1'b0;
            bus.primed       <= 1'b0;
            bus.cnt          <= '0;
        end else begin
            v1               <= bus.din_valid;
            fill             <= fill_nxt;
            bus.primed       <= fill_nxt == FILL_MAX;
            bus.x_filt_valid <= v1;
            if (bus.din_valid) begin
                acc     <= acc + acc_t'(bus.din) - acc_t'(oldest);
                wp      <= wp + 1'b1;
                bus.cnt <= bus.cnt + 1'b1;
            end
            if (v1) bus.x_filt <= sample_t'(acc >>> LOG2_TAPS);
        end
    end
endmodule
